// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter: step/load controls in,
// registered binary/Gray count and flags out.
interface gray_updown_counter_if #(
  parameter int COUNTER_WIDTH = 4
);
  logic                     Enable_in;
  logic                     Up_in;
  logic                     Load_in;
  logic [COUNTER_WIDTH-1:0] LoadValue_in;
  logic [COUNTER_WIDTH-1:0] BinaryCount_out;
  logic [COUNTER_WIDTH-1:0] GrayCount_out;
  logic [COUNTER_WIDTH-1:0] GrayCountNext_out;
  logic [COUNTER_WIDTH-1:0] GrayCountPrev_out;
  logic                     Wrap_out;
  logic                     AtMax_out;
  logic                     AtMin_out;

  modport master (
    output Enable_in, Up_in, Load_in, LoadValue_in,
    input  BinaryCount_out, GrayCount_out, GrayCountNext_out, GrayCountPrev_out,
    input  Wrap_out, AtMax_out, AtMin_out
  );

  modport slave (
    input  Enable_in, Up_in, Load_in, LoadValue_in,
    output BinaryCount_out, GrayCount_out, GrayCountNext_out, GrayCountPrev_out,
    output Wrap_out, AtMax_out, AtMin_out
  );
endinterface

// File: rtl/gray_updown_counter.sv
// Up/down binary counter with registered Gray encodings of the count and both
// modular neighbours, plus wrap and terminal-count flags, for CDC FIFO pointers.
module gray_updown_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int RESET_VALUE   = 0,
  parameter bit SATURATE      = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Reset_in,
  gray_updown_counter_if.slave   cnt_if
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] RST_VAL = COUNTER_WIDTH'(RESET_VALUE);

  function automatic logic [COUNTER_WIDTH-1:0] to_gray(input logic [COUNTER_WIDTH-1:0] x);
    return x ^ (x >> 1);
  endfunction

  logic [COUNTER_WIDTH-1:0] bin_q;
  logic [COUNTER_WIDTH-1:0] bin_nxt;
  logic                     wrap_nxt;
  logic [COUNTER_WIDTH-1:0] gray_q;
  logic [COUNTER_WIDTH-1:0] gray_next_q;
  logic [COUNTER_WIDTH-1:0] gray_prev_q;
  logic                     wrap_q;
  logic                     at_max_q;
  logic                     at_min_q;

  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (Reset_in) begin
      bin_nxt = RST_VAL;
    end else if (cnt_if.Load_in) begin
      bin_nxt = cnt_if.LoadValue_in;
    end else if (cnt_if.Enable_in) begin
      if (cnt_if.Up_in) begin
        if (bin_q != MAX_VAL) begin
          bin_nxt = bin_q + ONE;
        end else if (!SATURATE) begin
          bin_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (bin_q != '0) begin
          bin_nxt = bin_q - ONE;
        end else if (!SATURATE) begin
          bin_nxt  = MAX_VAL;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Every output is re-derived from bin_nxt so all of them describe the same count.
  always_ff @(posedge Clk) begin
    bin_q       <= bin_nxt;
    gray_q      <= to_gray(bin_nxt);
    gray_next_q <= to_gray(bin_nxt + ONE);
    gray_prev_q <= to_gray(bin_nxt - ONE);
    wrap_q      <= wrap_nxt;
    at_max_q    <= (bin_nxt == MAX_VAL);
    at_min_q    <= (bin_nxt == '0);
  end

  assign cnt_if.BinaryCount_out   = bin_q;
  assign cnt_if.GrayCount_out     = gray_q;
  assign cnt_if.GrayCountNext_out = gray_next_q;
  assign cnt_if.GrayCountPrev_out = gray_prev_q;
  assign cnt_if.Wrap_out          = wrap_q;
  assign cnt_if.AtMax_out         = at_max_q;
  assign cnt_if.AtMin_out         = at_min_q;

endmodule
